// File: rtl/dbus_write_buffer.sv
// dbus_write_buffer
// Posted-write buffer between the CPU data-bus master and the D$ slave.
// CPU writes retire immediately into a small FIFO and drain to memory in
// order. A write to the youngest buffered word can merge bytes into that
// entry. Reads bypass buffered writes unless they hit a buffered word (RAW),
// in which case the read is stalled until the matching writes have drained.
// Cache invalidates wait for the buffer to empty before being forwarded.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_read / cpu_write       CPU request strobes (mutually exclusive)
//   cpu_address                bus-word aligned byte address
//   cpu_byteenable/cpu_wrdata  write byte enables and data
//   cpu_icache_inv/dcache_inv  invalidate requests, held until cpu_stall=0
//   cpu_stall                  CPU must hold its request
//   cpu_rddata                 read data, valid when cpu_read & !cpu_stall
//   mem_read / mem_write       D$ request strobes
//   mem_address/byteenable/wrdata  D$ request fields
//   mem_icache_inv/dcache_inv  forwarded invalidates
//   mem_stall                  D$ busy, request must be held
//   mem_rddata                 D$ read data
//   count, empty               buffer occupancy
module dbus_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter bit MERGE_EN   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cpu_read,
    input  logic                      cpu_write,
    input  logic [ADDR_WIDTH-1:0]     cpu_address,
    input  logic [DATA_WIDTH/8-1:0]   cpu_byteenable,
    input  logic [DATA_WIDTH-1:0]     cpu_wrdata,
    input  logic                      cpu_icache_inv,
    input  logic                      cpu_dcache_inv,
    output logic                      cpu_stall,
    output logic [DATA_WIDTH-1:0]     cpu_rddata,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_WIDTH-1:0]     mem_address,
    output logic [DATA_WIDTH/8-1:0]   mem_byteenable,
    output logic [DATA_WIDTH-1:0]     mem_wrdata,
    output logic                      mem_icache_inv,
    output logic                      mem_dcache_inv,
    input  logic                      mem_stall,
    input  logic [DATA_WIDTH-1:0]     mem_rddata,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty
);

    localparam int BE_W     = DATA_WIDTH / 8;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int WORD_LSB = $clog2(BE_W);

    typedef enum logic [1:0] {IDLE, BUSY_RD, BUSY_WR, BUSY_INV} state_t;

    state_t state, state_d;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [BE_W-1:0]       be_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    logic [PTR_W-1:0]      wr_ptr, rd_ptr, young_ptr;
    logic [DEPTH-1:0]      valid, match;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [1:0]            inv_q;

    logic inv_req, full, raw_hit, read_go, write_go, inv_go;
    logic young_hit, head_locked, do_merge, do_enq, pop, inv_issue;

    assign inv_req   = cpu_icache_inv || cpu_dcache_inv;
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign young_ptr = wr_ptr - PTR_W'(1);

    // An entry is valid when its distance from the head is below count.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset = '0;
        valid  = '0;
        match  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset   = PTR_W'(i) - rd_ptr;
            valid[i] = ({1'b0, offset} < count);
            match[i] = valid[i] &&
                       (addr_q[i][ADDR_WIDTH-1:WORD_LSB] == cpu_address[ADDR_WIDTH-1:WORD_LSB]);
        end
    end

    assign raw_hit  = cpu_read && (|match);
    assign read_go  = (state == IDLE) && cpu_read && !raw_hit;
    assign write_go = (state == IDLE) && !read_go && !empty;
    assign inv_go   = (state == IDLE) && !read_go && empty && inv_req;

    assign young_hit = !empty &&
        (addr_q[young_ptr][ADDR_WIDTH-1:WORD_LSB] == cpu_address[ADDR_WIDTH-1:WORD_LSB]);

    // The head being presented on the mem port must stay stable, and when it
    // completes in IDLE it pops this very cycle, so a merge into it would be
    // lost either way; block merging whenever the youngest entry is that head.
    assign head_locked = mem_write && (young_ptr == rd_ptr);
    assign do_merge    = MERGE_EN && cpu_write && !inv_req && young_hit && !head_locked;
    assign pop         = mem_write && !mem_stall;
    assign do_enq      = cpu_write && !inv_req && !do_merge && (!full || pop);
    assign inv_issue   = mem_icache_inv || mem_dcache_inv;

    // Mem-port ownership: next state and the request presented to the D$.
    always_comb begin
        state_d        = state;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_wrdata     = '0;
        mem_icache_inv = 1'b0;
        mem_dcache_inv = 1'b0;
        case (state)
            IDLE: begin
                if (read_go) begin
                    mem_read    = 1'b1;
                    mem_address = cpu_address;
                    if (mem_stall) state_d = BUSY_RD;
                end else if (write_go) begin
                    mem_write      = 1'b1;
                    mem_address    = addr_q[rd_ptr];
                    mem_byteenable = be_q[rd_ptr];
                    mem_wrdata     = data_q[rd_ptr];
                    if (mem_stall) state_d = BUSY_WR;
                end else if (inv_go) begin
                    mem_icache_inv = cpu_icache_inv;
                    mem_dcache_inv = cpu_dcache_inv;
                    if (mem_stall) state_d = BUSY_INV;
                end
            end
            BUSY_RD: begin
                mem_read    = 1'b1;
                mem_address = rd_addr_q;
                if (!mem_stall) state_d = IDLE;
            end
            BUSY_WR: begin
                mem_write      = 1'b1;
                mem_address    = addr_q[rd_ptr];
                mem_byteenable = be_q[rd_ptr];
                mem_wrdata     = data_q[rd_ptr];
                if (!mem_stall) state_d = IDLE;
            end
            BUSY_INV: begin
                mem_icache_inv = inv_q[1];
                mem_dcache_inv = inv_q[0];
                if (!mem_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // CPU-side handshake. A read only proceeds while it owns the mem port.
    always_comb begin
        cpu_stall  = 1'b0;
        cpu_rddata = '0;
        if (cpu_read) begin
            if (mem_read) begin
                cpu_stall  = mem_stall;
                cpu_rddata = mem_rddata;
            end else begin
                cpu_stall = 1'b1;
            end
        end else if (cpu_write) begin
            cpu_stall = !(do_merge || do_enq);
        end else if (inv_req) begin
            cpu_stall = !(inv_issue && !mem_stall);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_addr_q <= '0;
            inv_q     <= '0;
        end else begin
            state <= state_d;
            if (do_enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_enq) - CNT_W'(pop);
            if (read_go) rd_addr_q <= cpu_address;
            if (inv_go)  inv_q     <= {cpu_icache_inv, cpu_dcache_inv};
        end
    end

    // Entry storage needs no reset: contents are only visible while counted.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            addr_q[wr_ptr] <= cpu_address;
            be_q[wr_ptr]   <= cpu_byteenable;
            data_q[wr_ptr] <= cpu_wrdata;
        end else if (do_merge) begin
            be_q[young_ptr] <= be_q[young_ptr] | cpu_byteenable;
            for (int b = 0; b < BE_W; b++) begin
                if (cpu_byteenable[b]) begin
                    data_q[young_ptr][8*b +: 8] <= cpu_wrdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dbus_write_buffer.sv
// tb_dbus_write_buffer
// Directed bench for dbus_write_buffer. Stimulus tasks push the expected
// D$ operation sequence into a scoreboard queue; a monitor pops and compares
// every completed mem-port operation. A second instance with merging
// disabled shares the stimulus to check the non-merging occupancy.
`timescale 1ns/1ps
module tb_dbus_write_buffer;

    localparam logic [1:0]  OP_WR   = 2'd0;
    localparam logic [1:0]  OP_RD   = 2'd1;
    localparam logic [1:0]  OP_DINV = 2'd2;
    localparam logic [1:0]  OP_IINV = 2'd3;
    localparam logic [31:0] RD_XOR  = 32'hA5A5_0000;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_read = 1'b0, cpu_write = 1'b0;
    logic [31:0] cpu_address = '0;
    logic [3:0]  cpu_byteenable = '0;
    logic [31:0] cpu_wrdata = '0;
    logic        cpu_icache_inv = 1'b0, cpu_dcache_inv = 1'b0;
    logic        mem_stall = 1'b0;
    logic [31:0] mem_rddata;

    logic        cpu_stall, mem_read, mem_write, mem_icache_inv, mem_dcache_inv, empty;
    logic [31:0] cpu_rddata, mem_address, mem_wrdata;
    logic [3:0]  mem_byteenable;
    logic [2:0]  count;

    logic        nm_cpu_stall, nm_mem_read, nm_mem_write, nm_mem_icache_inv, nm_mem_dcache_inv, nm_empty;
    logic [31:0] nm_cpu_rddata, nm_mem_address, nm_mem_wrdata;
    logic [3:0]  nm_mem_byteenable;
    logic [2:0]  nm_count;

    int  tests_run = 0;
    int  tests_failed = 0;
    op_t exp_q[$];

    always #5 clk = ~clk;

    // Memory read data is a fixed function of the address.
    assign mem_rddata = mem_address ^ RD_XOR;

    dbus_write_buffer #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MERGE_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_byteenable(cpu_byteenable), .cpu_wrdata(cpu_wrdata),
        .cpu_icache_inv(cpu_icache_inv), .cpu_dcache_inv(cpu_dcache_inv),
        .cpu_stall(cpu_stall), .cpu_rddata(cpu_rddata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_byteenable(mem_byteenable), .mem_wrdata(mem_wrdata),
        .mem_icache_inv(mem_icache_inv), .mem_dcache_inv(mem_dcache_inv),
        .mem_stall(mem_stall), .mem_rddata(mem_rddata),
        .count(count), .empty(empty)
    );

    dbus_write_buffer #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MERGE_EN(1'b0)) u_nm (
        .clk(clk), .rst_n(rst_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_byteenable(cpu_byteenable), .cpu_wrdata(cpu_wrdata),
        .cpu_icache_inv(cpu_icache_inv), .cpu_dcache_inv(cpu_dcache_inv),
        .cpu_stall(nm_cpu_stall), .cpu_rddata(nm_cpu_rddata),
        .mem_read(nm_mem_read), .mem_write(nm_mem_write), .mem_address(nm_mem_address),
        .mem_byteenable(nm_mem_byteenable), .mem_wrdata(nm_mem_wrdata),
        .mem_icache_inv(nm_mem_icache_inv), .mem_dcache_inv(nm_mem_dcache_inv),
        .mem_stall(mem_stall), .mem_rddata(32'h0),
        .count(nm_count), .empty(nm_empty)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [3:0] be, input logic [31:0] d,
                                 input logic iinv, input logic dinv);
        cpu_read       = rd;
        cpu_write      = wr;
        cpu_address    = a;
        cpu_byteenable = be;
        cpu_wrdata     = d;
        cpu_icache_inv = iinv;
        cpu_dcache_inv = dinv;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expOp(input logic [1:0] k, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        op_t e;
        e.kind = k; e.addr = a; e.be = be; e.data = d;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for the current CPU request to be accepted.
    task automatic waitAccept(input string name, output logic ok);
        int n = 0;
        @(negedge clk);
        while (cpu_stall && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = !cpu_stall;
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s: cpu_stall still 1 after %0d cycles, required 0", name, n);
        end
    endtask

    task automatic cpuWrite(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        logic ok;
        applyStimulus(1'b0, 1'b1, a, be, d, 1'b0, 1'b0);
        waitAccept("write_accept", ok);
        cycles(1);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic cpuRead(input logic [31:0] a, input logic [31:0] exp_data);
        logic ok;
        applyStimulus(1'b1, 1'b0, a, '0, '0, 1'b0, 1'b0);
        waitAccept("read_accept", ok);
        if (ok) checkOutput("read_rddata", cpu_rddata, exp_data);
        cycles(1);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic cpuInv(input logic iinv, input logic dinv);
        logic ok;
        applyStimulus(1'b0, 1'b0, '0, '0, '0, iinv, dinv);
        waitAccept("inv_accept", ok);
        cycles(1);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic waitEmpty(input string name);
        int n = 0;
        @(negedge clk);
        while (!empty && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(empty), 32'd1);
        cycles(1);
    endtask

    // Scoreboard monitor: compare each completed mem operation in order.
    always @(negedge clk) begin
        op_t act;
        op_t exp;
        if (rst_n && (mem_write || mem_read || mem_dcache_inv || mem_icache_inv) && !mem_stall) begin
            act.kind = mem_write ? OP_WR : (mem_read ? OP_RD : (mem_dcache_inv ? OP_DINV : OP_IINV));
            act.addr = (mem_write || mem_read) ? mem_address : 32'h0;
            act.be   = mem_byteenable;
            act.data = mem_write ? mem_wrdata : 32'h0;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL mem_op_unexpected: got kind=%0d addr=0x%0h be=0x%0h data=0x%0h, required none",
                         act.kind, act.addr, act.be, act.data);
            end else begin
                exp = exp_q.pop_front();
                if (act.kind !== exp.kind || act.addr !== exp.addr || act.be !== exp.be || act.data !== exp.data) begin
                    tests_failed++;
                    $display("[TB] FAIL mem_op: got kind=%0d addr=0x%0h be=0x%0h data=0x%0h, required kind=%0d addr=0x%0h be=0x%0h data=0x%0h",
                             act.kind, act.addr, act.be, act.data, exp.kind, exp.addr, exp.be, exp.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_mem_write", 32'(mem_write), 32'd0);
        checkOutput("reset_cpu_stall", 32'(cpu_stall), 32'd0);
        cycles(2);
        rst_n = 1'b1;
        cycles(1);

        // Reset mid-drain with three entries buffered
        mem_stall = 1'b1;
        cpuWrite(32'h10, 4'hF, 32'hA000_0010);
        cpuWrite(32'h14, 4'hF, 32'hA000_0014);
        cpuWrite(32'h18, 4'hF, 32'hA000_0018);
        cpuWrite(32'h1C, 4'hF, 32'hA000_001C);
        expOp(OP_WR, 32'h10, 4'hF, 32'hA000_0010);
        mem_stall = 1'b0;
        cycles(1);
        mem_stall = 1'b1;
        checkOutput("middrain_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
        checkOutput("rst_mem_address", mem_address, 32'd0);
        checkOutput("rst_mem_wrdata", mem_wrdata, 32'd0);
        checkOutput("rst_mem_byteenable", 32'(mem_byteenable), 32'd0);
        mem_stall = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(5);
        checkOutput("post_rst_count", 32'(count), 32'd0);

        // Full buffer: fifth write stalls until a pop frees an entry
        mem_stall = 1'b1;
        cpuWrite(32'h100, 4'hF, 32'hB000_0100);
        cpuWrite(32'h104, 4'hF, 32'hB000_0104);
        cpuWrite(32'h108, 4'hF, 32'hB000_0108);
        cpuWrite(32'h10C, 4'hF, 32'hB000_010C);
        checkOutput("full_count", 32'(count), 32'd4);
        expOp(OP_WR, 32'h100, 4'hF, 32'hB000_0100);
        expOp(OP_WR, 32'h104, 4'hF, 32'hB000_0104);
        expOp(OP_WR, 32'h108, 4'hF, 32'hB000_0108);
        expOp(OP_WR, 32'h10C, 4'hF, 32'hB000_010C);
        expOp(OP_WR, 32'h110, 4'hF, 32'hB000_0110);
        fork
            cpuWrite(32'h110, 4'hF, 32'hB000_0110);
            begin
                @(negedge clk);
                checkOutput("full_stall", 32'(cpu_stall), 32'd1);
                cycles(1);
                mem_stall = 1'b0;
                cycles(1);
                mem_stall = 1'b1;
            end
        join
        checkOutput("full_after_pop_count", 32'(count), 32'd4);
        mem_stall = 1'b0;
        waitEmpty("full_drain_empty");

        // Byte merge into the youngest entry
        mem_stall = 1'b1;
        cpuWrite(32'h1FC, 4'hF, 32'h1111_11FC);
        cpuWrite(32'h200, 4'h3, 32'h0000_BEEF);
        cpuWrite(32'h200, 4'hC, 32'hDEAD_0000);
        checkOutput("merge_count", 32'(count), 32'd2);
        checkOutput("nomerge_count", 32'(nm_count), 32'd3);
        expOp(OP_WR, 32'h1FC, 4'hF, 32'h1111_11FC);
        expOp(OP_WR, 32'h200, 4'hF, 32'hDEAD_BEEF);
        mem_stall = 1'b0;
        waitEmpty("merge_drain_empty");
        cycles(2);

        // RAW hit: read stalls until the matching write drains
        mem_stall = 1'b1;
        cpuWrite(32'h300, 4'hF, 32'h0000_0011);
        expOp(OP_WR, 32'h300, 4'hF, 32'h0000_0011);
        expOp(OP_RD, 32'h300, 4'h0, 32'h0);
        fork
            cpuRead(32'h300, 32'hA5A5_0300);
            begin
                @(negedge clk);
                checkOutput("raw_stall_0", 32'(cpu_stall), 32'd1);
                @(negedge clk);
                checkOutput("raw_stall_1", 32'(cpu_stall), 32'd1);
                cycles(1);
                mem_stall = 1'b0;
                @(negedge clk);
                checkOutput("raw_stall_on_drain", 32'(cpu_stall), 32'd1);
            end
        join

        // Non-matching read bypasses a buffered write
        mem_stall = 1'b1;
        cpuWrite(32'h300, 4'hF, 32'h0000_0022);
        expOp(OP_RD, 32'h400, 4'h0, 32'h0);
        expOp(OP_WR, 32'h300, 4'hF, 32'h0000_0022);
        fork
            cpuRead(32'h400, 32'hA5A5_0400);
            begin
                @(negedge clk);
                checkOutput("bypass_mem_read", 32'(mem_read), 32'd1);
                checkOutput("bypass_mem_address", mem_address, 32'h400);
                cycles(1);
                mem_stall = 1'b0;
            end
        join
        waitEmpty("bypass_drain_empty");

        // Held head write is not disturbed by an arriving read
        mem_stall = 1'b1;
        cpuWrite(32'h480, 4'hF, 32'h0000_0055);
        cycles(1);
        expOp(OP_WR, 32'h480, 4'hF, 32'h0000_0055);
        expOp(OP_RD, 32'h500, 4'h0, 32'h0);
        fork
            cpuRead(32'h500, 32'hA5A5_0500);
            begin
                @(negedge clk);
                checkOutput("lock_mem_write", 32'(mem_write), 32'd1);
                checkOutput("lock_mem_address_0", mem_address, 32'h480);
                checkOutput("lock_cpu_stall", 32'(cpu_stall), 32'd1);
                cycles(1);
                @(negedge clk);
                checkOutput("lock_mem_address_1", mem_address, 32'h480);
                cycles(1);
                mem_stall = 1'b0;
                @(negedge clk);
                checkOutput("lock_no_read_on_release", 32'(mem_read), 32'd0);
                cycles(1);
                @(negedge clk);
                checkOutput("lock_read_next", 32'(mem_read), 32'd1);
                checkOutput("lock_read_address", mem_address, 32'h500);
            end
        join

        // D$ invalidate waits behind two buffered writes
        mem_stall = 1'b1;
        cpuWrite(32'h600, 4'hF, 32'h0000_0066);
        cpuWrite(32'h604, 4'hF, 32'h0000_0067);
        expOp(OP_WR, 32'h600, 4'hF, 32'h0000_0066);
        expOp(OP_WR, 32'h604, 4'hF, 32'h0000_0067);
        expOp(OP_DINV, 32'h0, 4'h0, 32'h0);
        fork
            cpuInv(1'b0, 1'b1);
            begin
                @(negedge clk);
                checkOutput("inv_stall_0", 32'(cpu_stall), 32'd1);
                cycles(1);
                mem_stall = 1'b0;
                @(negedge clk);
                checkOutput("inv_stall_drain_0", 32'(cpu_stall), 32'd1);
                @(negedge clk);
                checkOutput("inv_stall_drain_1", 32'(cpu_stall), 32'd1);
            end
        join

        // I$ invalidate held by a busy D$
        mem_stall = 1'b1;
        expOp(OP_IINV, 32'h0, 4'h0, 32'h0);
        fork
            cpuInv(1'b1, 1'b0);
            begin
                @(negedge clk);
                checkOutput("iinv_issue", 32'(mem_icache_inv), 32'd1);
                checkOutput("iinv_stall_0", 32'(cpu_stall), 32'd1);
                cycles(1);
                @(negedge clk);
                checkOutput("iinv_hold", 32'(mem_icache_inv), 32'd1);
                checkOutput("iinv_stall_1", 32'(cpu_stall), 32'd1);
                cycles(1);
                mem_stall = 1'b0;
            end
        join

        cycles(3);
        checkOutput("final_empty", 32'(empty), 32'd1);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
